ifft_bfly_pipe: RTL and testbench
=================================

Name: ifft_bfly_pipe

Overview:
- Pipelined radix-2 decimation-in-time butterfly for the inverse FFT path; the counterpart of the forward DIF butterfly.
- Computes t = conj(W)·B, then out1 = (A + t)/2 and out2 = (A − t)/2.
- The per-stage 1/2 scaling realises the 1/N IFFT normalisation across log2(N) stages.
- Sits between the IFFT stage memories. Valid/ready streaming with a runtime twiddle input, unlike the forward butterfly's fixed parameter twiddle.

Parameters:
- WIDTH, 16, data sample width; signed two's complement, real and imaginary parts each.
- TW_WIDTH, 16, twiddle width; signed Q1.(TW_WIDTH-1), so 0x7FFF ≈ +1.0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a_r, a_i  in  WIDTH each  upper butterfly operand A.
- b_r, b_i  in  WIDTH each  lower butterfly operand B.
- w_r, w_i  in  TW_WIDTH each  forward twiddle W; the block conjugates it internally.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out1_r, out1_i  out  WIDTH each  (A+t)/2.
- out2_r, out2_i  out  WIDTH each  (A−t)/2.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - On rst_n low, every stage valid bit clears immediately and all data registers clear to 0.
  - out_valid and all outputs read 0 during and after reset.
  - Reset mid-operation discards all in-flight beats; no beat emerges after release.
- Pipeline: 3 register stages; latency is exactly 3 cycles from an accepted input to out_valid, with no stalls.
  - S1 registers the four full-width products plus A (and A's valid): br·wr, bi·wi, bi·wr, br·wi.
  - S2 forms tr = br·wr + bi·wi and ti = bi·wr − br·wi.
    - Rounding: add 2^(TW_WIDTH-2), arithmetic shift right by TW_WIDTH-1.
    - Keep WIDTH+2 bits; the magnitude can reach √2·2^(WIDTH-1).
    - A is forwarded alongside.
  - S3 computes s1 = A + t and s2 = A − t at WIDTH+3 bits.
    - Scaling: add 1, arithmetic shift right by 1 (round half up).
    - The result is reduced to WIDTH per the optional feature.
- Handshake: global enable en = !out_valid | out_ready.
  - in_ready = en. A beat is accepted when in_valid & in_ready.
  - When en = 0, all stages hold and no bubble is collapsed. Throughput is 1 beat/cycle when out_ready is held high.
  - Bubbles (in_valid = 0 with en = 1) propagate as invalid stage slots.
  - Output data is stable while out_valid & !out_ready.
  - in_ready has a combinational path from out_ready; this is accepted.
- Ordering: strict FIFO order, no reordering or drops.
- Twiddle corner: W = −1 (0x8000, 0) is legal.
  - conj(W) = −1, so t = −B.
  - The product and sum widths above cover it without internal overflow.

Optional Feature:
- Macro IFFT_BFLY_SAT_EN.
- Defined: the S3 results are clamped to [−2^(WIDTH-1), 2^(WIDTH-1)−1] after scaling.
- Undefined: the S3 results are truncated to the low WIDTH bits (two's complement wrap); no extra logic.
- Latency and handshake are identical in both builds.

Test Plan:
- Real passthrough (WIDTH = TW_WIDTH = 16): A = (1000, 0), B = (200, 0), W = (0x7FFF, 0) -> out1 = (600, 0) and out2 = (400, 0), 3 cycles after acceptance.
- Conjugation check: A = (0, 0), B = (0, 100), W = (0, 0x7FFF) -> t = 100; out1 = (50, 0), out2 = (−50, 0).
- Overflow: A = (32767, 0), B = (32767, 32767), W = (23170, 23170) -> out2_r = −6786.
  - With IFFT_BFLY_SAT_EN: out1_r = 32767.
  - Without it: out1_r = −25983.
- Backpressure: stream 8 beats with out_ready toggling 1,0,0,1,… -> all 8 outputs in order, none lost or duplicated; outputs hold while stalled.
  - in_ready = 0 exactly on cycles with out_valid & !out_ready.
- Reset mid-stream: accept 3 beats, assert rst_n low for 1 cycle -> out_valid = 0 immediately, no stale beat after release; the next beat emerges 3 cycles after its acceptance.
- Throughput: in_valid and out_ready held high for 16 cycles -> 16 consecutive out_valid cycles starting at cycle 3.

Source files
------------

// File: rtl/ifft_bfly_pipe_if.sv
// Valid/ready stream bundle for the IFFT DIT butterfly: operand beat in, result beat out.
// The block drives through the slave modport; the upstream/downstream side uses master.
interface ifft_bfly_pipe_if #(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [WIDTH-1:0]    a_r;
    logic signed [WIDTH-1:0]    a_i;
    logic signed [WIDTH-1:0]    b_r;
    logic signed [WIDTH-1:0]    b_i;
    logic signed [TW_WIDTH-1:0] w_r;
    logic signed [TW_WIDTH-1:0] w_i;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [WIDTH-1:0]    out1_r;
    logic signed [WIDTH-1:0]    out1_i;
    logic signed [WIDTH-1:0]    out2_r;
    logic signed [WIDTH-1:0]    out2_i;

    modport master (
        output in_valid, a_r, a_i, b_r, b_i, w_r, w_i, out_ready,
        input  in_ready, out_valid, out1_r, out1_i, out2_r, out2_i
    );

    modport slave (
        input  in_valid, a_r, a_i, b_r, b_i, w_r, w_i, out_ready,
        output in_ready, out_valid, out1_r, out1_i, out2_r, out2_i
    );
endinterface

// File: rtl/ifft_bfly_pipe.sv
// 3-stage radix-2 DIT butterfly for the inverse FFT: t = conj(W)*B, out = (A +/- t)/2.
// Define IFFT_BFLY_SAT_EN to clamp the scaled results; otherwise they wrap to WIDTH bits.
module ifft_bfly_pipe #(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ifft_bfly_pipe_if.slave  bus
);
    localparam int PW  = WIDTH + TW_WIDTH;
    localparam int SW  = PW + 1;
    localparam int TWD = WIDTH + 2;
    localparam int S3W = WIDTH + 3;

    localparam logic signed [SW-1:0]  RND  = {{(SW-1){1'b0}}, 1'b1} << (TW_WIDTH - 2);
    localparam logic signed [S3W-1:0] ONE3 = {{(S3W-1){1'b0}}, 1'b1};

    logic                    w_en;
    logic                    r_v1;
    logic                    r_v2;
    logic                    r_v3;
    logic signed [PW-1:0]    r_p_rr;
    logic signed [PW-1:0]    r_p_ii;
    logic signed [PW-1:0]    r_p_ir;
    logic signed [PW-1:0]    r_p_ri;
    logic signed [WIDTH-1:0] r_a1_r;
    logic signed [WIDTH-1:0] r_a1_i;
    logic signed [WIDTH-1:0] r_a2_r;
    logic signed [WIDTH-1:0] r_a2_i;
    logic signed [TWD-1:0]   r_t_r;
    logic signed [TWD-1:0]   r_t_i;
    logic signed [WIDTH-1:0] r_o1_r;
    logic signed [WIDTH-1:0] r_o1_i;
    logic signed [WIDTH-1:0] r_o2_r;
    logic signed [WIDTH-1:0] r_o2_i;
    logic signed [SW-1:0]    w_sum_r;
    logic signed [SW-1:0]    w_sum_i;
    logic signed [S3W-1:0]   w_s1_r;
    logic signed [S3W-1:0]   w_s1_i;
    logic signed [S3W-1:0]   w_s2_r;
    logic signed [S3W-1:0]   w_s2_i;
    logic signed [WIDTH-1:0] w_o1_r;
    logic signed [WIDTH-1:0] w_o1_i;
    logic signed [WIDTH-1:0] w_o2_r;
    logic signed [WIDTH-1:0] w_o2_i;
    logic                    w_unused;

    // One global enable: every stage advances together, bubbles keep their slots.
    assign w_en         = !r_v3 | bus.out_ready;
    assign bus.in_ready = w_en;

    // Conjugated twiddle: tr = br*wr + bi*wi, ti = bi*wr - br*wi, rounded back to Q0.
    assign w_sum_r = SW'(r_p_rr) + SW'(r_p_ii) + RND;
    assign w_sum_i = SW'(r_p_ir) - SW'(r_p_ri) + RND;

    assign w_s1_r = S3W'(r_a2_r) + S3W'(r_t_r) + ONE3;
    assign w_s1_i = S3W'(r_a2_i) + S3W'(r_t_i) + ONE3;
    assign w_s2_r = S3W'(r_a2_r) - S3W'(r_t_r) + ONE3;
    assign w_s2_i = S3W'(r_a2_i) - S3W'(r_t_i) + ONE3;

`ifdef IFFT_BFLY_SAT_EN
    localparam logic signed [WIDTH+1:0] MAXV = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] MINV = {3'b111, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] f_sat(input logic signed [WIDTH+1:0] v);
        logic signed [WIDTH-1:0] res;
        if (v > MAXV) begin
            res = MAXV[WIDTH-1:0];
        end else if (v < MINV) begin
            res = MINV[WIDTH-1:0];
        end else begin
            res = v[WIDTH-1:0];
        end
        return res;
    endfunction

    assign w_o1_r   = f_sat(w_s1_r[S3W-1:1]);
    assign w_o1_i   = f_sat(w_s1_i[S3W-1:1]);
    assign w_o2_r   = f_sat(w_s2_r[S3W-1:1]);
    assign w_o2_i   = f_sat(w_s2_i[S3W-1:1]);
    assign w_unused = ^{w_s1_r[0], w_s1_i[0], w_s2_r[0], w_s2_i[0],
                        w_sum_r[TW_WIDTH-2:0], w_sum_i[TW_WIDTH-2:0]};
`else
    assign w_o1_r   = w_s1_r[WIDTH:1];
    assign w_o1_i   = w_s1_i[WIDTH:1];
    assign w_o2_r   = w_s2_r[WIDTH:1];
    assign w_o2_i   = w_s2_i[WIDTH:1];
    assign w_unused = ^{w_s1_r[S3W-1:WIDTH+1], w_s1_i[S3W-1:WIDTH+1],
                        w_s2_r[S3W-1:WIDTH+1], w_s2_i[S3W-1:WIDTH+1],
                        w_s1_r[0], w_s1_i[0], w_s2_r[0], w_s2_i[0],
                        w_sum_r[TW_WIDTH-2:0], w_sum_i[TW_WIDTH-2:0]};
`endif

    // Stage 1: full-width products of B and W, A carried alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_p_rr <= '0;
            r_p_ii <= '0;
            r_p_ir <= '0;
            r_p_ri <= '0;
            r_a1_r <= '0;
            r_a1_i <= '0;
        end else if (w_en) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_p_rr <= PW'(bus.b_r) * PW'(bus.w_r);
                r_p_ii <= PW'(bus.b_i) * PW'(bus.w_i);
                r_p_ir <= PW'(bus.b_i) * PW'(bus.w_r);
                r_p_ri <= PW'(bus.b_r) * PW'(bus.w_i);
                r_a1_r <= bus.a_r;
                r_a1_i <= bus.a_i;
            end
        end
    end

    // Stage 2: rounded t = conj(W)*B at WIDTH+2 bits (W = -1 with B = -2^(WIDTH-1) fits).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_t_r  <= '0;
            r_t_i  <= '0;
            r_a2_r <= '0;
            r_a2_i <= '0;
        end else if (w_en) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_t_r  <= w_sum_r[TW_WIDTH-1 +: TWD];
                r_t_i  <= w_sum_i[TW_WIDTH-1 +: TWD];
                r_a2_r <= r_a1_r;
                r_a2_i <= r_a1_i;
            end
        end
    end

    // Stage 3: halved sum/difference registered straight onto the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3   <= 1'b0;
            r_o1_r <= '0;
            r_o1_i <= '0;
            r_o2_r <= '0;
            r_o2_i <= '0;
        end else if (w_en) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_o1_r <= w_o1_r;
                r_o1_i <= w_o1_i;
                r_o2_r <= w_o2_r;
                r_o2_i <= w_o2_i;
            end
        end
    end

    assign bus.out_valid = r_v3;
    assign bus.out1_r    = r_o1_r;
    assign bus.out1_i    = r_o1_i;
    assign bus.out2_r    = r_o2_r;
    assign bus.out2_i    = r_o2_i;
endmodule

// File: tb/tb_ifft_bfly_pipe.sv
// Self-checking bench for ifft_bfly_pipe: vector table, backpressure, mid-stream reset, throughput.
module tb_ifft_bfly_pipe;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifft_bfly_pipe_if #(.WIDTH(W), .TW_WIDTH(W)) bus();

    ifft_bfly_pipe #(.WIDTH(W), .TW_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic signed [15:0] ar, ai, br, bi, wr, wi;
    } in_t;
    typedef struct {
        logic signed [15:0] o1r, o1i, o2r, o2i;
    } out_t;
    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;
    typedef struct {
        out_t o;
        int   cyc;
        bit   lat;
    } sb_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    sb_t  sbq[$];
    bit   prev_stall = 1'b0;
    out_t prev_out;
    vec_t tab[5];

    function automatic logic signed [15:0] reduce(input longint s);
        longint h;
        h = (s + 64'sd1) >>> 1;
`ifdef IFFT_BFLY_SAT_EN
        if (h > 64'sd32767) h = 64'sd32767;
        else if (h < -64'sd32768) h = -64'sd32768;
`endif
        return h[15:0];
    endfunction

    function automatic out_t model(input in_t v);
        longint tr, ti;
        out_t   o;
        tr = (longint'(v.br) * longint'(v.wr) + longint'(v.bi) * longint'(v.wi) + 64'sd16384) >>> 15;
        ti = (longint'(v.bi) * longint'(v.wr) - longint'(v.br) * longint'(v.wi) + 64'sd16384) >>> 15;
        o.o1r = reduce(longint'(v.ar) + tr);
        o.o1i = reduce(longint'(v.ai) + ti);
        o.o2r = reduce(longint'(v.ar) - tr);
        o.o2i = reduce(longint'(v.ai) - ti);
        return o;
    endfunction

    function automatic vec_t mkv(input logic signed [15:0] ar, ai, br, bi, wr, wi,
                                 input logic signed [15:0] o1r, o1i, o2r, o2i);
        vec_t v;
        v.i = '{ar, ai, br, bi, wr, wi};
        v.o = '{o1r, o1i, o2r, o2i};
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input bit iv, input bit ordy, input in_t v, input out_t e,
                        input bit lat, output bit acc);
        out_t got;
        sb_t  s;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a_r = v.ar; bus.a_i = v.ai;
        bus.b_r = v.br; bus.b_i = v.bi;
        bus.w_r = v.wr; bus.w_i = v.wi;
        bus.out_ready = ordy;
        #1;
        got = '{bus.out1_r, bus.out1_i, bus.out2_r, bus.out2_i};
        if (prev_stall) begin
            chk("hold_valid", longint'(bus.out_valid), 1);
            chk("hold_out1_r", got.o1r, prev_out.o1r);
            chk("hold_out1_i", got.o1i, prev_out.o1i);
            chk("hold_out2_r", got.o2r, prev_out.o2r);
            chk("hold_out2_i", got.o2i, prev_out.o2i);
        end
        chk("in_ready", longint'(bus.in_ready), longint'(!(bus.out_valid && !bus.out_ready)));
        if (bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                s = sbq.pop_front();
                chk("out1_r", got.o1r, s.o.o1r);
                chk("out1_i", got.o1i, s.o.o1i);
                chk("out2_r", got.o2r, s.o.o2r);
                chk("out2_i", got.o2i, s.o.o2i);
                if (s.lat) chk("latency", cyc - s.cyc, 3);
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = got;
        acc        = iv && bus.in_ready;
        if (acc) sbq.push_back('{e, cyc, lat});
        cyc++;
    endtask

    task automatic drain(input int limit);
        in_t  zi;
        out_t zo;
        bit   acc;
        int   n;
        zi = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        zo = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        n  = 0;
        while (sbq.size() != 0 && n < limit) begin
            step(1'b0, 1'b1, zi, zo, 1'b0, acc);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
        // extra idle cycles expose duplicated beats
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, zi, zo, 1'b0, acc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t     zi;
        out_t    zo;
        in_t     v;
        bit      acc;
        bit      pat[4];
        int      sent;
        int      k;
        logic [31:0] rnd;

        zi  = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        zo  = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        tab[0] = mkv(16'sd1000, 16'sd0, 16'sd200, 16'sd0, 16'sh7FFF, 16'sd0,
                     16'sd600, 16'sd0, 16'sd400, 16'sd0);
        tab[1] = mkv(16'sd0, 16'sd0, 16'sd0, 16'sd100, 16'sd0, 16'sh7FFF,
                     16'sd50, 16'sd0, -16'sd50, 16'sd0);
`ifdef IFFT_BFLY_SAT_EN
        tab[2] = mkv(16'sd32767, 16'sd0, 16'sd32767, 16'sd32767, 16'sd23170, 16'sd23170,
                     16'sd32767, 16'sd0, -16'sd6786, 16'sd0);
`else
        tab[2] = mkv(16'sd32767, 16'sd0, 16'sd32767, 16'sd32767, 16'sd23170, 16'sd23170,
                     -16'sd25983, 16'sd0, -16'sd6786, 16'sd0);
`endif
        tab[3] = mkv(16'sd100, -16'sd50, 16'sh8000, 16'sd300, 16'sh8000, 16'sd0,
                     16'sd16434, -16'sd175, -16'sd16334, 16'sd125);
        tab[4] = mkv(-16'sd2, 16'sd3, 16'sd0, 16'sd0, 16'sh7FFF, 16'sh7FFF,
                     -16'sd1, 16'sd2, -16'sd1, 16'sd2);

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a_r = 16'sd0; bus.a_i = 16'sd0; bus.b_r = 16'sd0; bus.b_i = 16'sd0;
        bus.w_r = 16'sd0; bus.w_i = 16'sd0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out1_r", bus.out1_r, 0);
        chk("rst_out2_i", bus.out2_i, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // vector table, back-to-back with out_ready high
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, tab[i].i, tab[i].o, 1'b1, acc);
            chk("tab_accept", longint'(acc), 1);
        end
        drain(20);

        // backpressure: 8 beats, out_ready pattern 1,0,0,1
        sent = 0; k = 0;
        while (sent < 8 && k < 200) begin
            rnd = $urandom; v.ar = rnd[15:0]; v.ai = rnd[31:16];
            rnd = $urandom; v.br = rnd[15:0]; v.bi = rnd[31:16];
            rnd = $urandom; v.wr = rnd[15:0]; v.wi = rnd[31:16];
            step(1'b1, pat[k % 4], v, model(v), 1'b0, acc);
            if (acc) sent++;
            k++;
        end
        chk("bp_sent", sent, 8);
        while (sbq.size() != 0 && k < 400) begin
            step(1'b0, pat[k % 4], zi, zo, 1'b0, acc);
            k++;
        end
        chk("bp_all_out", sbq.size(), 0);
        drain(20);

        // reset mid-stream
        for (int i = 0; i < 3; i++) begin
            v = tab[i].i;
            step(1'b1, 1'b1, v, model(v), 1'b0, acc);
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        chk("midrst_out1_r", bus.out1_r, 0);
        sbq.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, zi, zo, 1'b0, acc);
            chk("post_rst_no_valid", longint'(bus.out_valid), 0);
        end
        step(1'b1, 1'b1, tab[0].i, tab[0].o, 1'b1, acc);
        chk("post_rst_accept", longint'(acc), 1);
        drain(20);

        // throughput: 16 beats back-to-back, each exactly 3 cycles late
        for (int i = 0; i < 16; i++) begin
            v = '{16'(i * 100), 16'(-i), 16'(i * 37), 16'(i * 11), 16'sh5A82, -16'sh5A82};
            step(1'b1, 1'b1, v, model(v), 1'b1, acc);
            chk("tp_accept", longint'(acc), 1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, zi, zo, 1'b0, acc);
        end
        chk("tp_drained", sbq.size(), 0);
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
